// File: rtl/vip_stream_pkg.sv
// Shared definitions for the VIP pixel-stream blocks (source now, sinks later).
package vip_stream_pkg;

  localparam int PIX_W = 24;  // {R[23:16], G[15:8], B[7:0]}
  localparam int CNT_W = 11;  // pixel / line counters
  localparam int BLK_W = 8;   // blanking / porch counter

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_LINE   = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VFRONT = 3'd5
  } state_e;

  // Reload value for the shared down-counter: a phase lasts (load + 1)
  // cycles, and a programmed length of 0 still lasts one cycle.
  function automatic logic [BLK_W-1:0] blank_load(input logic [BLK_W-1:0] cyc);
    return (cyc == '0) ? '0 : cyc - BLK_W'(1);
  endfunction

endpackage

// File: rtl/vip_stream_source_if.sv
// Upstream pixel beat channel (FIFO / frame-buffer reader -> stream source).
//
// Handshake: a beat transfers on a rising clk edge where s_valid && s_ready.
// The master holds s_data/s_sof stable while s_valid is high and not yet
// accepted; s_ready may depend combinationally on s_valid/s_sof.
interface vip_stream_source_if;
  import vip_stream_pkg::*;

  logic [PIX_W-1:0] s_data;
  logic             s_sof;
  logic             s_valid;
  logic             s_ready;

  modport master (output s_data, output s_sof, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_sof, input  s_valid, output s_ready);

endinterface

// File: rtl/vip_stream_source.sv
// Frame-synchronous video stream transmitter. Pulls pixels over a
// valid/ready channel and emits vsync/href/clken + 24-bit RGB with
// programmable sync gap, back porch, line blanking and front porch.
module vip_stream_source
  import vip_stream_pkg::*;
#(
  parameter logic [CNT_W-1:0] IMG_HDISP = 11'd800,
  parameter logic [CNT_W-1:0] IMG_VDISP = 11'd600,
  parameter logic [BLK_W-1:0] H_BLANK   = 8'd16,
  parameter logic [BLK_W-1:0] VS_CYC    = 8'd8,
  parameter logic [BLK_W-1:0] VB_CYC    = 8'd8,
  parameter logic [BLK_W-1:0] VF_CYC    = 8'd8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  vip_stream_source_if.slave   s_if,
  output logic                 post_frame_vsync,
  output logic                 post_frame_href,
  output logic                 post_frame_clken,
  output logic [PIX_W-1:0]     post_img_data,
  output logic                 frame_done,
  output logic                 err_sof,
  output logic                 err_underrun,
  output state_e               dbg_state_o
);

  localparam logic [CNT_W-1:0] H_LAST = IMG_HDISP - CNT_W'(1);
  localparam logic [CNT_W-1:0] V_LAST = IMG_VDISP - CNT_W'(1);

  state_e           state_q;
  logic [BLK_W-1:0] blk_q;
  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] vcnt_q;
  logic             armed_q;
  logic             vsync_q;
  logic             href_q;
  logic             clken_q;
  logic [PIX_W-1:0] data_q;
  logic             done_q;
  logic             err_sof_q;
  logic             err_und_q;

  logic blk_end;
  logic in_line;
  logic line_acc;
  logic flush_ok;
  logic at_origin;

  assign blk_end   = (blk_q == '0);
  assign in_line   = (state_q == ST_LINE);
  assign line_acc  = in_line && s_if.s_valid;
  assign at_origin = (hcnt_q == '0) && (vcnt_q == '0);

  // Before a frame the source drops every beat that is not an SOF, so the
  // first pixel taken in LINE is normally the frame's SOF. armed_q is low
  // for the first cycle after reset so s_ready comes out of reset at 0
  // regardless of what the upstream is presenting.
  assign flush_ok = armed_q && ((state_q == ST_IDLE) || (state_q == ST_VSYNC));

  assign s_if.s_ready = in_line || (flush_ok && s_if.s_valid && !s_if.s_sof);

  assign post_frame_vsync = vsync_q;
  assign post_frame_href  = href_q;
  assign post_frame_clken = clken_q;
  assign post_img_data    = data_q;
  assign frame_done       = done_q;
  assign err_sof          = err_sof_q;
  assign err_underrun     = err_und_q;
  assign dbg_state_o      = state_q;

  // Frame sequencer: state, counters and all registered stream outputs.
  // href/vsync are the state decoded one cycle late, so they line up with
  // the clken/data of the beats accepted in that state. frame_done is
  // registered on the same edge that leaves VFRONT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      blk_q     <= '0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      armed_q   <= 1'b0;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      clken_q   <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_sof_q <= 1'b0;
      err_und_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      href_q  <= in_line;
      vsync_q <= (state_q == ST_VBACK) || in_line || (state_q == ST_HBLANK);
      clken_q <= line_acc;
      done_q  <= 1'b0;

      if (line_acc) begin
        data_q <= s_if.s_data;
      end
      // A misplaced SOF is only flagged; the pixel is still emitted.
      if (line_acc && s_if.s_sof && !at_origin) begin
        err_sof_q <= 1'b1;
      end
      if (in_line && !s_if.s_valid) begin
        err_und_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q <= ST_VSYNC;
            blk_q   <= blank_load(VS_CYC);
          end
        end
        ST_VSYNC: begin
          if (blk_end) begin
            state_q <= ST_VBACK;
            blk_q   <= blank_load(VB_CYC);
          end else begin
            blk_q <= blk_q - BLK_W'(1);
          end
        end
        ST_VBACK: begin
          if (blk_end) begin
            state_q <= ST_LINE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
          end else begin
            blk_q <= blk_q - BLK_W'(1);
          end
        end
        ST_LINE: begin
          if (line_acc) begin
            if (hcnt_q == H_LAST) begin
              state_q <= ST_HBLANK;
              hcnt_q  <= '0;
              blk_q   <= blank_load(H_BLANK);
            end else begin
              hcnt_q <= hcnt_q + CNT_W'(1);
            end
          end
        end
        ST_HBLANK: begin
          if (blk_end) begin
            if (vcnt_q == V_LAST) begin
              state_q <= ST_VFRONT;
              blk_q   <= blank_load(VF_CYC);
            end else begin
              state_q <= ST_LINE;
              vcnt_q  <= vcnt_q + CNT_W'(1);
            end
          end else begin
            blk_q <= blk_q - BLK_W'(1);
          end
        end
        ST_VFRONT: begin
          if (blk_end) begin
            done_q <= 1'b1;
            if (enable) begin
              state_q <= ST_VSYNC;
              blk_q   <= blank_load(VS_CYC);
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            blk_q <= blk_q - BLK_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vip_stream_source.sv
// Directed bench for vip_stream_source on a 4x3 frame with short blanking.
module tb_vip_stream_source;
  import vip_stream_pkg::*;

  localparam logic [CNT_W-1:0] HD = 11'd4;
  localparam logic [CNT_W-1:0] VD = 11'd3;
  localparam logic [BLK_W-1:0] HB = 8'd2;
  localparam logic [BLK_W-1:0] VS = 8'd3;
  localparam logic [BLK_W-1:0] VB = 8'd2;
  localparam logic [BLK_W-1:0] VF = 8'd2;
  localparam int NPIX      = 12;
  localparam int FRAME_CYC = 3 + 2 + 3 * (4 + 2) + 2;  // 25

  typedef struct {
    logic [PIX_W-1:0] data;
    logic             sof;
    int               gap;
  } beat_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  initial forever #5 clk = ~clk;

  vip_stream_source_if s_if ();

  logic             post_frame_vsync;
  logic             post_frame_href;
  logic             post_frame_clken;
  logic [PIX_W-1:0] post_img_data;
  logic             frame_done;
  logic             err_sof;
  logic             err_underrun;
  state_e           dbg_state;

  vip_stream_source #(
    .IMG_HDISP(HD), .IMG_VDISP(VD), .H_BLANK(HB),
    .VS_CYC(VS), .VB_CYC(VB), .VF_CYC(VF)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .s_if             (s_if.slave),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_data    (post_img_data),
    .frame_done       (frame_done),
    .err_sof          (err_sof),
    .err_underrun     (err_underrun),
    .dbg_state_o      (dbg_state)
  );

  int tests_run  = 0;
  int tests_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- source driver ----------------
  beat_t src_q[$];
  logic  hs_q = 1'b0;

  always @(posedge clk) hs_q <= s_if.s_valid && s_if.s_ready;

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_sof   = 1'b0;
    s_if.s_data  = '0;
    forever begin
      @(negedge clk);
      if (hs_q && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0 && src_q[0].gap > 0) begin
        src_q[0].gap = src_q[0].gap - 1;
        s_if.s_valid = 1'b0;
      end else if (src_q.size() > 0) begin
        s_if.s_valid = 1'b1;
        s_if.s_data  = src_q[0].data;
        s_if.s_sof   = src_q[0].sof;
      end else begin
        s_if.s_valid = 1'b0;
        s_if.s_sof   = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [PIX_W-1:0] exp_q[$];
  int   n_clken  = 0;
  int   cur_len  = 0;
  int   cur_gap  = 0;
  int   href_runs[$];
  int   gap_runs[$];
  logic href_prev = 1'b0;

  always @(negedge clk) begin
    if (post_frame_clken) begin
      n_clken++;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_fail++;
        $error("FAIL sb_extra_pixel observed=%0h expected=none", post_img_data);
      end else begin
        check("pixel_data", 32'(post_img_data), 32'(exp_q.pop_front()));
      end
    end
    if (post_frame_href) begin
      cur_len++;
      if (!post_frame_clken) cur_gap++;
    end else if (href_prev) begin
      href_runs.push_back(cur_len);
      gap_runs.push_back(cur_gap);
      cur_len = 0;
      cur_gap = 0;
    end
    href_prev = post_frame_href;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_frame(input logic [PIX_W-1:0] base, input int sof2,
                            input int gap_idx, input int gap_len, input bit push_exp);
    beat_t b;
    for (int i = 0; i < NPIX; i++) begin
      b.data = base + PIX_W'(i);
      b.sof  = (i == 0) || (i == sof2);
      b.gap  = (i == gap_idx) ? gap_len : 0;
      src_q.push_back(b);
      if (push_exp) exp_q.push_back(b.data);
    end
  endtask

  // One-cycle reset, then flush bench queues once the DUT is idle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    src_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_state(input string tag, input state_e s, input int limit);
    int n;
    n = 0;
    while (dbg_state !== s && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(dbg_state), 32'(s));
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < limit);
  endtask

  task automatic check_outputs_reset(input string pfx);
    check({pfx, "_s_ready"}, 32'(s_if.s_ready), 32'(0));
    check({pfx, "_vsync"}, 32'(post_frame_vsync), 32'(0));
    check({pfx, "_href"}, 32'(post_frame_href), 32'(0));
    check({pfx, "_clken"}, 32'(post_frame_clken), 32'(0));
    check({pfx, "_data"}, 32'(post_img_data), 32'(0));
    check({pfx, "_frame_done"}, 32'(frame_done), 32'(0));
    check({pfx, "_err_sof"}, 32'(err_sof), 32'(0));
    check({pfx, "_err_underrun"}, 32'(err_underrun), 32'(0));
    check({pfx, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Run one frame that is started from IDLE and released immediately.
  task automatic run_single(input string tag, input int exp_len);
    int n;
    enable = 1'b1;
    wait_state({tag, "_vsync_entry"}, ST_VSYNC, 5);
    enable = 1'b0;
    wait_done(60, n);
    check({tag, "_frame_len"}, 32'(n), 32'(exp_len));
    check({tag, "_idle_after"}, 32'(dbg_state), 32'(ST_IDLE));
    tick(3);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int clk0, runs0, n, bad;

    // Reset values.
    do_reset();
    check_outputs_reset("reset");

    // A: clean frame, data 0..11.
    clk0 = n_clken; runs0 = href_runs.size();
    load_frame(24'h000000, -1, -1, 0, 1'b1);
    run_single("a", FRAME_CYC);
    check("a_clken_count", 32'(n_clken - clk0), 32'(NPIX));
    check("a_sb_drained", 32'(exp_q.size()), 32'(0));
    check("a_line_count", 32'(href_runs.size() - runs0), 32'(3));
    for (int l = 0; l < 3; l++) begin
      check($sformatf("a_href_len%0d", l), 32'(href_runs[runs0 + l]), 32'(4));
    end
    check("a_err_sof", 32'(err_sof), 32'(0));
    check("a_err_underrun", 32'(err_underrun), 32'(0));

    // B: 3-cycle underrun at pixel 2 of line 1.
    do_reset();
    clk0 = n_clken; runs0 = href_runs.size();
    load_frame(24'h0A0000, -1, 6, 3, 1'b1);
    run_single("b", FRAME_CYC + 3);
    check("b_clken_count", 32'(n_clken - clk0), 32'(NPIX));
    check("b_href_len0", 32'(href_runs[runs0]), 32'(4));
    check("b_href_len1", 32'(href_runs[runs0 + 1]), 32'(7));
    check("b_href_len2", 32'(href_runs[runs0 + 2]), 32'(4));
    check("b_gap_line1", 32'(gap_runs[runs0 + 1]), 32'(3));
    check("b_gap_line0", 32'(gap_runs[runs0]), 32'(0));
    check("b_err_underrun", 32'(err_underrun), 32'(1));
    check("b_err_sof", 32'(err_sof), 32'(0));

    // C: two junk beats without SOF ahead of the frame.
    do_reset();
    clk0 = n_clken;
    src_q.push_back('{data: 24'hAAAAAA, sof: 1'b0, gap: 0});
    src_q.push_back('{data: 24'hBBBBBB, sof: 1'b0, gap: 0});
    load_frame(24'h000100, -1, -1, 0, 1'b1);
    tick(3);
    check("c_junk_flushed", 32'(src_q.size()), 32'(NPIX));
    check("c_no_clken_idle", 32'(n_clken - clk0), 32'(0));
    run_single("c", FRAME_CYC);
    check("c_clken_count", 32'(n_clken - clk0), 32'(NPIX));
    check("c_sb_drained", 32'(exp_q.size()), 32'(0));
    check("c_err_sof", 32'(err_sof), 32'(0));

    // D: extra SOF on pixel (1,1).
    do_reset();
    clk0 = n_clken;
    load_frame(24'h000300, 5, -1, 0, 1'b1);
    run_single("d", FRAME_CYC);
    check("d_err_sof", 32'(err_sof), 32'(1));
    check("d_err_underrun", 32'(err_underrun), 32'(0));
    check("d_clken_count", 32'(n_clken - clk0), 32'(NPIX));
    check("d_sb_drained", 32'(exp_q.size()), 32'(0));

    // E: reset mid line 1 with enable held, then back-to-back frames.
    do_reset();
    load_frame(24'h000400, -1, -1, 0, 1'b1);
    enable = 1'b1;
    wait_state("e_vsync_entry", ST_VSYNC, 5);
    wait_state("e_line0", ST_LINE, 20);
    wait_state("e_hblank0", ST_HBLANK, 10);
    wait_state("e_line1", ST_LINE, 10);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check_outputs_reset("midrst");
    #1;
    src_q.delete();
    exp_q.delete();
    clk0 = n_clken;
    load_frame(24'h000500, -1, -1, 0, 1'b1);
    load_frame(24'h000600, -1, -1, 0, 1'b1);
    wait_state("e_restart", ST_VSYNC, 5);
    wait_done(60, n);
    check("e_frame1_len", 32'(n), 32'(FRAME_CYC));
    check("e_b2b_vsync", 32'(dbg_state), 32'(ST_VSYNC));
    check("e_frame1_clken", 32'(n_clken - clk0), 32'(NPIX));
    tick(10);
    enable = 1'b0;
    wait_done(60, n);
    check("e_frame2_len", 32'(n + 10), 32'(FRAME_CYC));
    check("e_idle_after", 32'(dbg_state), 32'(ST_IDLE));
    #1;
    load_frame(24'h000700, -1, -1, 0, 1'b0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dbg_state !== ST_IDLE || post_frame_vsync || post_frame_href || frame_done) bad++;
    end
    check("e_stays_idle", 32'(bad), 32'(0));
    check("e_clken_total", 32'(n_clken - clk0), 32'(2 * NPIX));
    check("e_sb_drained", 32'(exp_q.size()), 32'(0));
    check("e_err_sof", 32'(err_sof), 32'(0));
    check("e_err_underrun", 32'(err_underrun), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
